// File: rtl/wb_irq_timer_pkg.sv
// ============================================================================
// Module  : wb_irq_timer_pkg
// Brief   : Shared register-map constants and status type for wb_irq_timer.
// Revision: 1.0 - initial parametrised multi-channel release
// ============================================================================
`default_nettype none

package wb_irq_timer_pkg;

    localparam int   c_MAX_CH   = 8;
    localparam logic c_OFS_CTRL = 1'b1;

    localparam int c_BIT_EN   = 0;
    localparam int c_BIT_AUTO = 1;
    localparam int c_BIT_IRQ  = 2;
    localparam int c_BIT_OVR  = 3;

    typedef struct packed {
        logic ovr;
        logic irq;
        logic reload;
        logic en;
    } ch_status_t;

    function automatic logic [31:0] status_word(input ch_status_t s);
        logic [31:0] w;
        w             = '0;
        w[c_BIT_EN]   = s.en;
        w[c_BIT_AUTO] = s.reload;
        w[c_BIT_IRQ]  = s.irq;
        w[c_BIT_OVR]  = s.ovr;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_irq_timer_ch.sv
// ============================================================================
// Module  : wb_irq_timer_ch
// Brief   : One timer channel: counter, period, EN/AUTO, IRQ/OVR flags.
// Revision: 1.0 - initial parametrised multi-channel release
// ============================================================================
`default_nettype none

module wb_irq_timer_ch
    import wb_irq_timer_pkg::*;
#(
    parameter int               CNT_W          = 28,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(28'h00fffff)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_period_we,
    input  logic [CNT_W-1:0] i_period_wdata,
    input  logic             i_ctrl_we,
    input  logic [1:0]       i_ctrl_wdata,
    input  logic             i_stat_rd,
    output logic [CNT_W-1:0] o_period,
    output ch_status_t       o_status
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_en;
    logic             r_auto;
    logic             r_irq;
    logic             r_ovr;
    logic             r_done;
    logic             w_term;

    // r_done marks a fired one-shot whose counter is parked at PERIOD
    assign w_term = r_en & (r_cnt == r_period) & ~r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_period <= DEFAULT_PERIOD;
            r_en     <= 1'b1;
            r_auto   <= 1'b0;
            r_irq    <= 1'b0;
            r_ovr    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (r_en) begin
                if (w_term) begin
                    if (r_auto) r_cnt <= '0;
                    else        r_done <= 1'b1;
                end else if (!r_done) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if (w_term) begin
                r_irq <= 1'b1;
                if (r_irq) r_ovr <= 1'b1;
            end

            if (i_stat_rd) begin
                r_ovr <= 1'b0;
                r_irq <= w_term;
                if (!r_auto) begin
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                end
            end

            if (i_period_we) begin
                r_period <= i_period_wdata;
                r_cnt    <= '0;
                r_done   <= 1'b0;
            end

            if (i_ctrl_we) begin
                r_en   <= i_ctrl_wdata[c_BIT_EN];
                r_auto <= i_ctrl_wdata[c_BIT_AUTO];
                // Restart from zero when disabling or newly enabling
                if (!i_ctrl_wdata[c_BIT_EN] || !r_en) begin
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                end
                if (i_ctrl_wdata[c_BIT_AUTO]) r_done <= 1'b0;
            end
        end
    end

    assign o_period = r_period;
    assign o_status = {r_ovr, r_irq, r_auto, r_en};

endmodule

`default_nettype wire

// File: rtl/wb_irq_timer.sv
// ============================================================================
// Module  : wb_irq_timer
// Brief   : Wishbone classic multi-channel interval timer with interrupts.
// Revision: 1.0 - initial parametrised multi-channel release
// ============================================================================
`default_nettype none

module wb_irq_timer
    import wb_irq_timer_pkg::*;
#(
    parameter int               N_CH           = 4,
    parameter int               CNT_W          = 28,
    parameter logic [29:0]      BASE_ADR       = 30'h3ffffff0,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(28'h00fffff)
)(
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic [31:2]     ADR_I,
    input  logic [31:0]     DAT_I,
    output logic [31:0]     DAT_O,
    input  logic            CYC_I,
    input  logic            STB_I,
    input  logic            WE_I,
    output logic            ACK_O,
    output logic            RTY_O,
    output logic [N_CH-1:0] interrupt_o,
    output logic            irq_any_o
);

    logic        w_take;
    logic [3:0]  w_ofs;
    logic [2:0]  w_ch;
    logic        w_is_ctrl;
    logic        w_ch_valid;
    logic        w_rty;
    logic [31:0] w_rdata;
    logic        w_unused;

    ch_status_t      w_status [c_MAX_CH];
    logic [31:0]     w_period [c_MAX_CH];
    logic [N_CH-1:0] w_irq;

    // A response cycle blocks a new access, giving the 2-cycle minimum
    assign w_take     = CYC_I & STB_I & (ADR_I[31:6] == BASE_ADR[29:4]) & ~ACK_O & ~RTY_O;
    assign w_ofs      = ADR_I[5:2];
    assign w_ch       = w_ofs[3:1];
    assign w_is_ctrl  = (w_ofs[0] == c_OFS_CTRL);
    assign w_ch_valid = (int'(w_ch) < N_CH);
    assign w_rty      = w_take & WE_I & ~w_is_ctrl & w_ch_valid & w_status[w_ch].en;
    assign w_unused   = &{1'b0, DAT_I};

    genvar gi;
    generate
        for (gi = 0; gi < c_MAX_CH; gi++) begin : g_ch
            if (gi < N_CH) begin : g_used
                logic             w_sel_ch;
                logic [CNT_W-1:0] w_per;

                assign w_sel_ch = w_take & (w_ch == 3'(gi));

                wb_irq_timer_ch #(
                    .CNT_W          (CNT_W),
                    .DEFAULT_PERIOD (DEFAULT_PERIOD)
                ) u_ch (
                    .clk            (CLK_I),
                    .rst            (RST_I),
                    .i_period_we    (w_sel_ch & WE_I & ~w_is_ctrl & ~w_status[gi].en),
                    .i_period_wdata (DAT_I[CNT_W-1:0]),
                    .i_ctrl_we      (w_sel_ch & WE_I & w_is_ctrl),
                    .i_ctrl_wdata   (DAT_I[1:0]),
                    .i_stat_rd      (w_sel_ch & ~WE_I & w_is_ctrl),
                    .o_period       (w_per),
                    .o_status       (w_status[gi])
                );

                assign w_period[gi] = 32'(w_per);
                assign w_irq[gi]    = w_status[gi].irq;
            end else begin : g_unused
                assign w_period[gi] = '0;
                assign w_status[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        if (w_ch_valid) begin
            w_rdata = w_is_ctrl ? status_word(w_status[w_ch]) : w_period[w_ch];
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            ACK_O <= 1'b0;
            RTY_O <= 1'b0;
            DAT_O <= '0;
        end else begin
            ACK_O <= w_take & ~w_rty;
            RTY_O <= w_rty;
            DAT_O <= (w_take & ~WE_I) ? w_rdata : '0;
        end
    end

    assign interrupt_o = w_irq;
    assign irq_any_o   = |w_irq;

endmodule

`default_nettype wire

// File: tb/tb_wb_irq_timer.sv
// ============================================================================
// Module  : tb_wb_irq_timer
// Brief   : Self-checking bench for wb_irq_timer against an event-time model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_irq_timer;

    localparam int          N_CH  = 4;
    localparam int          CNT_W = 28;
    localparam logic [29:0] BASE  = 30'h3ffffff0;
    localparam logic [27:0] DEF   = 28'h0000ff;
    localparam longint      NEVER = -1;

    logic            CLK_I = 1'b0;
    logic            RST_I = 1'b1;
    logic [31:2]     ADR_I = '0;
    logic [31:0]     DAT_I = '0;
    logic [31:0]     DAT_O;
    logic            CYC_I = 1'b0;
    logic            STB_I = 1'b0;
    logic            WE_I  = 1'b0;
    logic            ACK_O;
    logic            RTY_O;
    logic [N_CH-1:0] interrupt_o;
    logic            irq_any_o;

    wb_irq_timer #(
        .N_CH           (N_CH),
        .CNT_W          (CNT_W),
        .BASE_ADR       (BASE),
        .DEFAULT_PERIOD (DEF)
    ) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .ADR_I       (ADR_I),
        .DAT_I       (DAT_I),
        .DAT_O       (DAT_O),
        .CYC_I       (CYC_I),
        .STB_I       (STB_I),
        .WE_I        (WE_I),
        .ACK_O       (ACK_O),
        .RTY_O       (RTY_O),
        .interrupt_o (interrupt_o),
        .irq_any_o   (irq_any_o)
    );

    always #5 CLK_I = ~CLK_I;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each channel keeps the absolute cycle of its next terminal event
    longint      now = 0;
    logic [27:0] m_period [N_CH];
    bit          m_en     [N_CH];
    bit          m_auto   [N_CH];
    bit          m_irq    [N_CH];
    bit          m_ovr    [N_CH];
    longint      m_next   [N_CH];
    bit          m_ack = 1'b0;
    bit          m_rty = 1'b0;
    logic [31:0] m_dat = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit       take, vld, old_en, term_any;
        bit       term [N_CH];
        bit       irq0 [N_CH];
        bit       ovr0 [N_CH];
        bit [3:0] ofs;
        int       ch;
        if (RST_I) begin
            m_ack = 0; m_rty = 0; m_dat = '0;
            for (int c = 0; c < N_CH; c++) begin
                m_period[c] = DEF; m_en[c] = 1; m_auto[c] = 0;
                m_irq[c] = 0; m_ovr[c] = 0;
                m_next[c] = now + 1 + longint'(DEF);
            end
            now++;
            return;
        end
        take = CYC_I && STB_I && (ADR_I[31:6] == BASE[29:4]) && !m_ack && !m_rty;
        ofs  = ADR_I[5:2];
        ch   = int'(ofs[3:1]);
        vld  = ch < N_CH;
        for (int c = 0; c < N_CH; c++) begin
            irq0[c] = m_irq[c];
            ovr0[c] = m_ovr[c];
            term[c] = m_en[c] && (now == m_next[c]);
            if (term[c]) begin
                if (m_irq[c]) m_ovr[c] = 1;
                m_irq[c]  = 1;
                m_next[c] = m_auto[c] ? now + 1 + longint'(m_period[c]) : NEVER;
            end
        end
        m_ack = 0; m_rty = 0; m_dat = '0;
        if (take) begin
            if (!vld) begin
                m_ack = 1;
            end else if (WE_I && ofs[0]) begin
                m_ack  = 1;
                old_en = m_en[ch];
                m_en[ch] = DAT_I[0];
                if (!DAT_I[0]) m_next[ch] = NEVER;
                else if (!old_en) m_next[ch] = now + 1 + longint'(m_period[ch]);
                else if (DAT_I[1] && !m_auto[ch] && m_next[ch] == NEVER) m_next[ch] = now + 1;
                m_auto[ch] = DAT_I[1];
            end else if (WE_I) begin
                if (m_en[ch]) m_rty = 1;
                else begin
                    m_ack = 1;
                    m_period[ch] = DAT_I[27:0];
                end
            end else if (ofs[0]) begin
                m_ack = 1;
                m_dat = {28'd0, ovr0[ch], irq0[ch], m_auto[ch], m_en[ch]};
                term_any  = term[ch];
                m_ovr[ch] = 0;
                m_irq[ch] = term_any;
                if (!m_auto[ch] && m_en[ch]) m_next[ch] = now + 1 + longint'(m_period[ch]);
            end else begin
                m_ack = 1;
                m_dat = {4'd0, m_period[ch]};
            end
        end
        now++;
    endtask

    task automatic tick();
        logic [N_CH:0] exp_irq;
        @(posedge CLK_I);
        model_step();
        #1;
        exp_irq = '0;
        for (int c = 0; c < N_CH; c++) begin
            exp_irq[c]    = m_irq[c];
            exp_irq[N_CH] = exp_irq[N_CH] | m_irq[c];
        end
        check("resp", {ACK_O, RTY_O}, {m_ack, m_rty});
        check("dat", DAT_O, m_dat);
        check("irq", {irq_any_o, interrupt_o}, exp_irq);
    endtask

    task automatic wb(input bit we, input logic [3:0] ofs, input logic [31:0] d,
                      input bit hold, input bit miss,
                      output logic [31:0] rd, output bit ack, output bit rty);
        CYC_I = 1; STB_I = 1; WE_I = we; DAT_I = d;
        ADR_I = {miss ? (BASE[29:4] ^ 26'h1) : BASE[29:4], ofs};
        tick();
        rd = DAT_O; ack = ACK_O; rty = RTY_O;
        if (!hold) begin CYC_I = 0; STB_I = 0; WE_I = 0; end
        tick();
        CYC_I = 0; STB_I = 0; WE_I = 0;
    endtask

    initial begin
        logic [31:0] rd;
        bit          ack, rty;
        int          n;

        repeat (3) tick();
        check("rst_resp", {ACK_O, RTY_O}, 2'b00);
        check("rst_dat", DAT_O, 32'h0);
        check("rst_irq", {irq_any_o, interrupt_o}, 5'h0);

        RST_I = 0;
        n = 0;
        do begin tick(); n++; end while (!interrupt_o[0] && n < 1000);
        check("dflt_rise", n, 64'(DEF) + 1);

        wb(0, 4'h1, 0, 0, 0, rd, ack, rty);
        check("st0_dat", rd, 32'h5);
        check("st0_ack", {ack, rty}, 2'b10);
        check("irq0_clr", interrupt_o[0], 1'b0);
        wb(0, 4'h1, 0, 1, 0, rd, ack, rty);
        check("st0_reread", rd, 32'h1);

        wb(0, 4'h3, 0, 0, 0, rd, ack, rty);
        check("st1_dflt", rd, 32'h5);
        wb(1, 4'h3, 32'h0, 0, 0, rd, ack, rty);
        wb(1, 4'h2, 32'h3, 0, 0, rd, ack, rty);
        wb(1, 4'h3, 32'h3, 0, 0, rd, ack, rty);
        repeat (2) tick();
        check("ch1_early", interrupt_o[1], 1'b0);
        tick();
        check("ch1_rise", interrupt_o[1], 1'b1);
        repeat (4) tick();
        wb(0, 4'h3, 0, 0, 0, rd, ack, rty);
        check("st1_ovr", rd, 32'hF);

        wb(1, 4'h4, 32'h55, 0, 0, rd, ack, rty);
        check("ch2_rty", {ack, rty}, 2'b01);
        wb(0, 4'h4, 0, 0, 0, rd, ack, rty);
        check("ch2_per", rd, 32'(DEF));

        wb(1, 4'h7, 32'h0, 0, 0, rd, ack, rty);
        wb(1, 4'h6, 32'h0, 0, 0, rd, ack, rty);
        wb(1, 4'h7, 32'h3, 0, 0, rd, ack, rty);
        repeat (3) tick();
        wb(0, 4'h7, 0, 0, 0, rd, ack, rty);
        check("ch3_irq_bit", rd[2:0], 3'b111);
        check("ch3_irq_held", interrupt_o[3], 1'b1);

        wb(0, 4'hE, 0, 0, 0, rd, ack, rty);
        check("inv_rd", {ack, rty, rd}, {2'b10, 32'h0});
        wb(1, 4'hF, 32'h3, 0, 0, rd, ack, rty);
        check("inv_wr", {ack, rty}, 2'b10);

        for (int i = 0; i < 400; i++) begin
            logic [3:0]  ofs;
            logic [31:0] d;
            bit          we;
            ofs = 4'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 1));
            d   = ofs[0] ? $urandom() : ((32'($urandom_range(0, 15)) << 28) | 32'($urandom_range(0, 12)));
            wb(we, ofs, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), rd, ack, rty);
            repeat ($urandom_range(0, 6)) tick();
        end

        CYC_I = 1; STB_I = 1; WE_I = 0; ADR_I = {BASE[29:4], 4'h1}; RST_I = 1;
        tick();
        check("rstmid_resp", {ACK_O, RTY_O}, 2'b00);
        check("rstmid_irq", {irq_any_o, interrupt_o, DAT_O}, 37'h0);
        CYC_I = 0; STB_I = 0;
        tick();
        RST_I = 0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
